// File: rtl/memory_pkg.sv
// ============================================================================
// Module      : memory_pkg
// Description : Shared defaults and writeback-source encodings for the
//               memory pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package memory_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 18;
    localparam int DEF_REG_W  = 5;

    localparam logic SEL_ALU = 1'b0;
    localparam logic SEL_MEM = 1'b1;

    // Word accesses must land on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] low_addr);
        return (low_addr != 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/memory_wb_reg.sv
// ============================================================================
// Module      : memory_wb_reg
// Description : MEM/WB pipeline register, cleared asynchronously by reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_wb_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_W-1:0]  d_regdest,
    input  logic              d_writereg,
    input  logic [DATA_W-1:0] d_wbvalue,
    output logic [REG_W-1:0]  q_regdest,
    output logic              q_writereg,
    output logic [DATA_W-1:0] q_wbvalue
);

    logic [REG_W-1:0]  r_regdest;
    logic              r_writereg;
    logic [DATA_W-1:0] r_wbvalue;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_regdest  <= '0;
            r_writereg <= 1'b0;
            r_wbvalue  <= '0;
        end else begin
            r_regdest  <= d_regdest;
            r_writereg <= d_writereg;
            r_wbvalue  <= d_wbvalue;
        end
    end

    assign q_regdest  = r_regdest;
    assign q_writereg = r_writereg;
    assign q_wbvalue  = r_wbvalue;

endmodule

`default_nettype wire

// File: rtl/memory.sv
// ============================================================================
// Module      : memory
// Description : MEM pipeline stage: zero-wait memory-controller interface and
//               writeback register. Optional MEMORY_ALIGN_CHECK_EN adds a
//               misaligned-access detector that suppresses the access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory
    import memory_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_mem_readmem,
    input  logic              ex_mem_writemem,
    input  logic [DATA_W-1:0] ex_mem_regb,
    input  logic              ex_mem_selwsource,
    input  logic [REG_W-1:0]  ex_mem_regdest,
    input  logic              ex_mem_writereg,
    input  logic [DATA_W-1:0] ex_mem_wbvalue,
    output logic              mem_mc_rw,
    output logic              mem_mc_en,
    output logic [ADDR_W-1:0] mem_mc_addr,
    inout  wire  [DATA_W-1:0] mem_mc_data,
`ifdef MEMORY_ALIGN_CHECK_EN
    output logic              mem_misaligned,
`endif
    output logic [REG_W-1:0]  mem_wb_regdest,
    output logic              mem_wb_writereg,
    output logic [DATA_W-1:0] mem_wb_wbvalue
);

    logic              w_request;
    logic              w_block;
    logic              w_drive;
    logic              w_writereg;
    logic [DATA_W-1:0] w_wbvalue;

    assign w_request = ex_mem_readmem | ex_mem_writemem;

`ifdef MEMORY_ALIGN_CHECK_EN
    logic r_misaligned;

    assign w_block = w_request & is_misaligned(ex_mem_wbvalue[1:0]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_block;
        end
    end

    assign mem_misaligned = r_misaligned;
`else
    assign w_block = 1'b0;
`endif

    // Reset gates the request combinationally so the bus is freed mid-cycle.
    assign mem_mc_en   = w_request & ~reset & ~w_block;
    assign mem_mc_rw   = mem_mc_en & ex_mem_writemem;
    assign mem_mc_addr = ex_mem_wbvalue[ADDR_W-1:0];

    assign w_drive     = mem_mc_en & mem_mc_rw;
    assign mem_mc_data = w_drive ? ex_mem_regb : {DATA_W{1'bz}};

    assign w_wbvalue  = (ex_mem_selwsource == SEL_MEM) ? mem_mc_data : ex_mem_wbvalue;
    assign w_writereg = ex_mem_writereg & ~w_block;

    memory_wb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_wb_reg (
        .clock      (clock),
        .reset      (reset),
        .d_regdest  (ex_mem_regdest),
        .d_writereg (w_writereg),
        .d_wbvalue  (w_wbvalue),
        .q_regdest  (mem_wb_regdest),
        .q_writereg (mem_wb_writereg),
        .q_wbvalue  (mem_wb_wbvalue)
    );

endmodule

`default_nettype wire

// File: tb/tb_memory.sv
// ============================================================================
// Module      : tb_memory
// Description : Self-checking bench for the memory stage (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_mem_readmem;
    logic        ex_mem_writemem;
    logic [31:0] ex_mem_regb;
    logic        ex_mem_selwsource;
    logic [4:0]  ex_mem_regdest;
    logic        ex_mem_writereg;
    logic [31:0] ex_mem_wbvalue;
    logic        mem_mc_rw;
    logic        mem_mc_en;
    logic [17:0] mem_mc_addr;
    wire  [31:0] mem_mc_data;
    logic [4:0]  mem_wb_regdest;
    logic        mem_wb_writereg;
    logic [31:0] mem_wb_wbvalue;
`ifdef MEMORY_ALIGN_CHECK_EN
    logic        mem_misaligned;
`endif

    logic        bus_oe;
    logic [31:0] bus_drv;
    assign mem_mc_data = bus_oe ? bus_drv : 32'hzzzz_zzzz;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    memory dut (
        .clock             (clock),
        .reset             (reset),
        .ex_mem_readmem    (ex_mem_readmem),
        .ex_mem_writemem   (ex_mem_writemem),
        .ex_mem_regb       (ex_mem_regb),
        .ex_mem_selwsource (ex_mem_selwsource),
        .ex_mem_regdest    (ex_mem_regdest),
        .ex_mem_writereg   (ex_mem_writereg),
        .ex_mem_wbvalue    (ex_mem_wbvalue),
        .mem_mc_rw         (mem_mc_rw),
        .mem_mc_en         (mem_mc_en),
        .mem_mc_addr       (mem_mc_addr),
        .mem_mc_data       (mem_mc_data),
`ifdef MEMORY_ALIGN_CHECK_EN
        .mem_misaligned    (mem_misaligned),
`endif
        .mem_wb_regdest    (mem_wb_regdest),
        .mem_wb_writereg   (mem_wb_writereg),
        .mem_wb_wbvalue    (mem_wb_wbvalue)
    );

    task automatic drive(input logic rd, input logic wr, input logic [31:0] regb,
                         input logic sel, input logic [4:0] rd_idx, input logic wreg,
                         input logic [31:0] wbv);
        ex_mem_readmem    = rd;
        ex_mem_writemem   = wr;
        ex_mem_regb       = regb;
        ex_mem_selwsource = sel;
        ex_mem_regdest    = rd_idx;
        ex_mem_writereg   = wreg;
        ex_mem_wbvalue    = wbv;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        bus_oe = 1'b0;
        bus_drv = '0;
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (mem_wb_regdest !== 5'd0 || mem_wb_writereg !== 1'b0 || mem_wb_wbvalue !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got regdest=%0d writereg=%0b wbvalue=%0h, want 0/0/0",
                     mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_writeback_only();
        @(negedge clock);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 5'd9, 1'b1, 32'd8);
        bus_oe = 1'b0;
        #2;
        checks++;
        if (mem_mc_en !== 1'b0 || mem_mc_rw !== 1'b0 || mem_mc_addr !== 18'd8) begin
            errors++;
            $display("FAIL wb_only_mc: got en=%0b rw=%0b addr=%0d, want 0/0/8", mem_mc_en, mem_mc_rw, mem_mc_addr);
        end
        @(posedge clock);
        #1;
        checks++;
        if (mem_wb_regdest !== 5'd9 || mem_wb_writereg !== 1'b1 || mem_wb_wbvalue !== 32'd8) begin
            errors++;
            $display("FAIL wb_only_regs: got regdest=%0d writereg=%0b wbvalue=%0d, want 9/1/8",
                     mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue);
        end
    endtask

    task automatic test_load();
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 5'd3, 1'b1, 32'd8);
        bus_drv = 32'd8;
        bus_oe  = 1'b1;
        #2;
        checks++;
        if (mem_mc_en !== 1'b1 || mem_mc_rw !== 1'b0 || mem_mc_addr !== 18'd8) begin
            errors++;
            $display("FAIL load_mc: got en=%0b rw=%0b addr=%0d, want 1/0/8", mem_mc_en, mem_mc_rw, mem_mc_addr);
        end
        @(posedge clock);
        #1;
        checks++;
        if (mem_wb_wbvalue !== 32'd8 || mem_wb_writereg !== 1'b1 || mem_wb_regdest !== 5'd3) begin
            errors++;
            $display("FAIL load_regs: got wbvalue=%0d writereg=%0b regdest=%0d, want 8/1/3",
                     mem_wb_wbvalue, mem_wb_writereg, mem_wb_regdest);
        end
        bus_oe = 1'b0;
    endtask

    task automatic test_store();
        @(negedge clock);
        bus_oe = 1'b0;
        drive(1'b0, 1'b1, 32'd9, 1'b0, 5'd4, 1'b0, 32'd8);
        #2;
        checks++;
        if (mem_mc_en !== 1'b1 || mem_mc_rw !== 1'b1 || mem_mc_addr !== 18'd8 || mem_mc_data !== 32'd9) begin
            errors++;
            $display("FAIL store_mc: got en=%0b rw=%0b addr=%0d data=%0h, want 1/1/8/9",
                     mem_mc_en, mem_mc_rw, mem_mc_addr, mem_mc_data);
        end
        // Read and write together is a write.
        ex_mem_readmem = 1'b1;
        #1;
        checks++;
        if (mem_mc_rw !== 1'b1 || mem_mc_data !== 32'd9) begin
            errors++;
            $display("FAIL store_rdwr: got rw=%0b data=%0h, want 1/9", mem_mc_rw, mem_mc_data);
        end
        @(posedge clock);
        #1;
        checks++;
        if (mem_wb_writereg !== 1'b0 || mem_wb_wbvalue !== 32'd8) begin
            errors++;
            $display("FAIL store_regs: got writereg=%0b wbvalue=%0d, want 0/8", mem_wb_writereg, mem_wb_wbvalue);
        end
    endtask

    task automatic test_reset_mid_access();
        test_writeback_only();
        @(negedge clock);
        // A released bus must read back exactly the bench's pattern.
        drive(1'b0, 1'b1, 32'h5A5A_0F0F, 1'b1, 5'd7, 1'b1, 32'd12);
        #1;
        reset   = 1'b1;
        bus_drv = 32'hA5A5_F0F0;
        bus_oe  = 1'b1;
        #1;
        checks++;
        if (mem_wb_regdest !== 5'd0 || mem_wb_writereg !== 1'b0 || mem_wb_wbvalue !== 32'd0) begin
            errors++;
            $display("FAIL reset_async_regs: got %0d/%0b/%0h, want 0/0/0",
                     mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue);
        end
        checks++;
        if (mem_mc_en !== 1'b0 || mem_mc_rw !== 1'b0 || mem_mc_data !== 32'hA5A5_F0F0) begin
            errors++;
            $display("FAIL reset_bus: got en=%0b rw=%0b data=%0h, want 0/0/a5a5f0f0",
                     mem_mc_en, mem_mc_rw, mem_mc_data);
        end
        #1;
        reset  = 1'b0;
        bus_oe = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (mem_wb_regdest !== 5'd7 || mem_wb_writereg !== 1'b1 || mem_wb_wbvalue !== 32'h5A5A_0F0F) begin
            errors++;
            $display("FAIL reset_first_edge: got %0d/%0b/%0h, want 7/1/5a5a0f0f",
                     mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue);
        end
    endtask

    // Random traffic against a transaction-level model of the stage.
    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            logic        rd, wr, sel, wreg;
            logic [31:0] regb, wbv, mem_rdata, exp_bus, exp_wbv;
            logic [4:0]  idx;
            logic [17:0] exp_addr;
            rd   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            sel  = 1'($urandom_range(0, 1));
            wreg = 1'($urandom_range(0, 1));
            regb = $urandom;
            wbv  = $urandom;
`ifdef MEMORY_ALIGN_CHECK_EN
            wbv  = wbv - (wbv % 4);
`endif
            idx  = 5'($urandom_range(0, 31));
            mem_rdata = $urandom;

            exp_addr = 18'(wbv % (1 << 18));
            exp_bus  = wr ? regb : mem_rdata;
            exp_wbv  = sel ? exp_bus : wbv;

            @(negedge clock);
            drive(rd, wr, regb, sel, idx, wreg, wbv);
            bus_drv = mem_rdata;
            bus_oe  = !wr;
            #2;
            checks++;
            if (mem_mc_en !== (rd || wr) || mem_mc_rw !== wr || mem_mc_addr !== exp_addr ||
                mem_mc_data !== exp_bus) begin
                errors++;
                $display("FAIL rand_mc[%0d]: got en=%0b rw=%0b addr=%0h data=%0h, want %0b/%0b/%0h/%0h",
                         i, mem_mc_en, mem_mc_rw, mem_mc_addr, mem_mc_data,
                         (rd || wr), wr, exp_addr, exp_bus);
            end
            @(posedge clock);
            #1;
            checks++;
            if (mem_wb_regdest !== idx || mem_wb_writereg !== wreg || mem_wb_wbvalue !== exp_wbv) begin
                errors++;
                $display("FAIL rand_wb[%0d]: got %0d/%0b/%0h, want %0d/%0b/%0h",
                         i, mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue, idx, wreg, exp_wbv);
            end
        end
        bus_oe = 1'b0;
    endtask

`ifdef MEMORY_ALIGN_CHECK_EN
    task automatic test_align();
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 5'd2, 1'b1, 32'd6);
        bus_drv = 32'h1234;
        bus_oe  = 1'b1;
        #2;
        checks++;
        if (mem_mc_en !== 1'b0) begin
            errors++;
            $display("FAIL align_en: got en=%0b, want 0", mem_mc_en);
        end
        @(posedge clock);
        #1;
        checks++;
        if (mem_misaligned !== 1'b1 || mem_wb_writereg !== 1'b0) begin
            errors++;
            $display("FAIL align_regs: got misaligned=%0b writereg=%0b, want 1/0",
                     mem_misaligned, mem_wb_writereg);
        end
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 5'd2, 1'b1, 32'd4);
        @(posedge clock);
        #1;
        checks++;
        if (mem_misaligned !== 1'b0 || mem_wb_writereg !== 1'b1) begin
            errors++;
            $display("FAIL align_ok: got misaligned=%0b writereg=%0b, want 0/1",
                     mem_misaligned, mem_wb_writereg);
        end
        bus_oe = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_writeback_only();
        test_load();
        test_store();
        test_reset_mid_access();
        test_random();
`ifdef MEMORY_ALIGN_CHECK_EN
        test_align();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data, register-operand and writeback value width.
REQ-002 The block SHALL have parameter ADDR_W, default 18, meaning memory-controller address width.
REQ-003 The block SHALL have parameter REG_W, default 5, meaning destination register index width.
REQ-004 The block SHALL have port clock  input  1  the single clock; all registers are rising-edge triggered.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port ex_mem_readmem  input  1  load request from execute.
REQ-007 The block SHALL have port ex_mem_writemem  input  1  store request from execute.
REQ-008 The block SHALL have port ex_mem_regb  input  DATA_W  store data.
REQ-009 The block SHALL have port ex_mem_selwsource  input  1  writeback source select: 1 = memory data, 0 = ALU value.
REQ-010 The block SHALL have port ex_mem_regdest  input  REG_W  destination register index.
REQ-011 The block SHALL have port ex_mem_writereg  input  1  register-write enable.
REQ-012 The block SHALL have port ex_mem_wbvalue  input  DATA_W  ALU result, also the memory address.
REQ-013 The block SHALL have port mem_mc_rw  output  1  1 = write, 0 = read.
REQ-014 The block SHALL have port mem_mc_en  output  1  memory access enable.
REQ-015 The block SHALL have port mem_mc_addr  output  ADDR_W  access address.
REQ-016 The block SHALL have port mem_mc_data  inout  DATA_W  bidirectional memory data bus.
REQ-017 The block SHALL have port mem_wb_regdest  output  REG_W  registered destination index.
REQ-018 The block SHALL have port mem_wb_writereg  output  1  registered register-write enable.
REQ-019 The block SHALL have port mem_wb_wbvalue  output  DATA_W  registered writeback value.

Function
REQ-020 mem_mc_en SHALL be combinational: ex_mem_readmem OR ex_mem_writemem, forced 0 while reset is high.
REQ-021 mem_mc_rw SHALL be combinational: equal to ex_mem_writemem when mem_mc_en is 1, otherwise 0.
REQ-022 mem_mc_addr SHALL always equal ex_mem_wbvalue[ADDR_W-1:0], combinationally.
REQ-023 The block SHALL drive mem_mc_data with ex_mem_regb when mem_mc_en and mem_mc_rw are both 1, and SHALL hold it at high-Z otherwise.
REQ-024 Simultaneous readmem and writemem SHALL be treated as a write (rw = 1).
REQ-025 On each rising clock edge, mem_wb_regdest SHALL capture ex_mem_regdest and mem_wb_writereg SHALL capture ex_mem_writereg, with 1-cycle latency.
REQ-026 On each rising clock edge, mem_wb_wbvalue SHALL capture mem_mc_data when ex_mem_selwsource = 1, otherwise ex_mem_wbvalue.
REQ-027 Read data SHALL be returned by the controller in the same cycle (zero-wait memory); the block SHALL have no stall or handshake.
REQ-028 Writeback fields SHALL pass through unchanged for non-memory instructions.

Reset
REQ-029 While reset is high, mem_wb_regdest, mem_wb_writereg and mem_wb_wbvalue SHALL be 0 immediately, independent of the clock.
REQ-030 Reset asserted mid-access SHALL deassert mem_mc_en and release mem_mc_data within the same cycle.
REQ-031 The first clock edge after reset release SHALL capture normally.

Configuration
REQ-032 With MEMORY_ALIGN_CHECK_EN defined, the block SHALL add output mem_misaligned (1 bit, registered, reset 0) set when an access has mem_mc_addr[1:0] != 0.
REQ-033 With MEMORY_ALIGN_CHECK_EN defined, a misaligned access SHALL force mem_mc_en to 0 and mem_wb_writereg to 0.
REQ-034 Without MEMORY_ALIGN_CHECK_EN, the mem_misaligned port and the check SHALL be absent.

Structure
REQ-035 Package memory_pkg SHALL hold DATA_W, ADDR_W and REG_W defaults and the selwsource encodings (SEL_ALU = 0, SEL_MEM = 1).
REQ-036 The writeback pipeline register SHALL be one sub-module, memory_wb_reg, with the memory-controller logic kept in the top level.

Verification
REQ-037 Writeback-only case: readmem=0, writemem=0, selwsource=0, regdest=9, writereg=1, wbvalue=8, one edge -> en=0, rw=0, addr=8, wb_regdest=9, wb_writereg=1, wb_wbvalue=8.
REQ-038 Load case: readmem=1, selwsource=1, wbvalue=8, bench drives mem_mc_data=8, one edge -> en=1, rw=0, addr=8, wb_wbvalue=8, wb_writereg=1.
REQ-039 Store case: writemem=1, regb=9, wbvalue=8, writereg=0, bench releases the bus -> en=1, rw=1, addr=8, mem_mc_data=9, wb_writereg=0.
REQ-040 Reset case: assert reset between edges after a writeback-only cycle -> all mem_wb_* outputs 0 immediately, en=0, bus high-Z.
REQ-041 Alignment case (MEMORY_ALIGN_CHECK_EN defined): readmem=1, wbvalue=6 -> en=0, and after one edge mem_misaligned=1 and wb_writereg=0.
